shift_reg_universal: RTL and testbench

//   Parametrised universal shift register, successor to the fixed 8-bit PIPO register.

---
 rtl/shift_reg_universal.sv | 107 ++++++++++
 tb/tb_shift_reg_universal.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_universal.sv
// Universal shift register: parallel load, multi-step logical shift or rotate in either
// direction, one bit per clock, with busy/done handshake.
module shift_reg_universal #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   d,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   q,
  output logic               serial_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [1:0] M_SHL = 2'b00;
  localparam logic [1:0] M_SHR = 2'b01;
  localparam logic [1:0] M_ROL = 2'b10;

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         mode_r;
  logic               done_r;
  logic [WIDTH-1:0]   step_q;
  logic               step_so;
  logic               last_step;

  assign last_step = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!load && start && amount != '0) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = done_r;
  end

  // One 1-bit step of the latched operation; serial_in is sampled live each step.
  always_comb begin
    step_q  = q;
    step_so = serial_out;
    case (mode_r)
      M_SHL: begin
        step_q  = {q[WIDTH-2:0], serial_in};
        step_so = q[WIDTH-1];
      end
      M_SHR: begin
        step_q  = {serial_in, q[WIDTH-1:1]};
        step_so = q[0];
      end
      M_ROL: begin
        step_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        step_so = q[WIDTH-1];
      end
      default: begin
        step_q  = {q[0], q[WIDTH-1:1]};
        step_so = q[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q          <= '0;
      serial_out <= 1'b0;
      cnt        <= '0;
      mode_r     <= M_SHL;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (load) begin
          q <= d;
        end else if (start) begin
          mode_r <= mode;
          cnt    <= amount;
          // Zero-length op completes immediately without entering SHIFT.
          if (amount == '0) done_r <= 1'b1;
        end
      end else begin
        q          <= step_q;
        serial_out <= step_so;
        cnt        <= cnt - SHAMT_W'(1);
        if (last_step) done_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench: directed literal cases plus randomized traffic against an
// arithmetic reference model, compared on every falling clock edge.
module tb_shift_reg_universal;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] d;
  logic       start;
  logic [1:0] mode;
  logic [3:0] amount;
  logic       serial_in;
  logic [7:0] q;
  logic       serial_out, busy, done;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  shift_reg_universal #(.WIDTH(8), .SHAMT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .d(d), .start(start), .mode(mode),
    .amount(amount), .serial_in(serial_in), .q(q), .serial_out(serial_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register value as an integer 0..255, one arithmetic step per edge.
  int m_q, m_so, m_busy, m_done, m_rem, m_mode;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0;
    end else begin
      m_done = 0;
      if (m_busy == 0) begin
        if (load) m_q = int'(d);
        else if (start) begin
          m_mode = int'(mode);
          if (amount == 0) m_done = 1;
          else begin m_busy = 1; m_rem = int'(amount); end
        end
      end else begin
        case (m_mode)
          0: begin m_so = m_q / 128; m_q = (m_q * 2 + int'(serial_in)) % 256; end
          1: begin m_so = m_q % 2;   m_q = m_q / 2 + int'(serial_in) * 128; end
          2: begin m_so = m_q / 128; m_q = (m_q * 2) % 256 + m_so; end
          default: begin m_so = m_q % 2; m_q = m_q / 2 + m_so * 128; end
        endcase
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("model_q",    int'(q),          m_q);
      chk("model_so",   int'(serial_out), m_so);
      chk("model_busy", int'(busy),       m_busy);
      chk("model_done", int'(done),       m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] val);
    load = 1'b1; d = val;
    tick();
    load = 1'b0;
  endtask

  // Launch an op, wait (bounded) for done, then check result, busy length, serial_out.
  task automatic run_op(input string name, input logic [1:0] m, input logic [3:0] a,
                        input logic sin, input int exp_q, input int exp_busy, input int exp_so);
    int bc;
    bit got;
    bc = 0; got = 1'b0;
    mode = m; amount = a; serial_in = sin; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) bc++;
      tick();
    end
    chk({name, "_done_seen"}, int'(got), 1);
    chk({name, "_q"}, int'(q), exp_q);
    chk({name, "_busy_cycles"}, bc, exp_busy);
    if (exp_so >= 0) chk({name, "_so"}, int'(serial_out), exp_so);
    tick();
    chk({name, "_done_single"}, int'(done), 0);
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; d = '0; start = 1'b0; mode = '0; amount = '0;
    serial_in = 1'b0;
    #12;
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_so", int'(serial_out), 0);
    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;

    do_load(8'hFF);
    chk("load_ff", int'(q), 'hFF);
    chk("load_msb", int'(q[7]), 1);
    do_load(8'hA5);
    chk("load_a5", int'(q), 'hA5);

    run_op("shl3", 2'b00, 4'd3, 1'b0, 'h28, 3, 1);
    do_load(8'hA5);
    run_op("ror4", 2'b11, 4'd4, 1'b0, 'h5A, 4, 0);
    do_load(8'hA5);
    run_op("rol8", 2'b10, 4'd8, 1'b1, 'hA5, 8, -1);
    do_load(8'h81);
    run_op("shr10", 2'b01, 4'd10, 1'b1, 'hFF, 10, 1);
    run_op("amt0", 2'b00, 4'd0, 1'b0, 'hFF, 0, 1);

    // load/start during SHIFT must not disturb a running SHL 4 of 0x3C with fill 1.
    do_load(8'h3C);
    mode = 2'b00; amount = 4'd4; serial_in = 1'b1; start = 1'b1;
    tick();
    load = 1'b1; d = 8'h00; mode = 2'b11; amount = 4'd1;
    for (int i = 0; i < 3; i++) tick();
    chk("ignore_busy", int'(busy), 1);
    tick();
    load = 1'b0; start = 1'b0;
    chk("ignore_done", int'(done), 1);
    chk("ignore_q", int'(q), 'hCF);

    // Asynchronous reset in the middle of a shift.
    do_load(8'h5A);
    mode = 2'b10; amount = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_q", int'(q), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_so", int'(serial_out), 0);
    #1 reset_n = 1'b1;
    tick();

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      load      = ($urandom_range(0, 9) == 0);
      d         = 8'($urandom);
      start     = ($urandom_range(0, 2) == 0);
      mode      = 2'($urandom);
      amount    = 4'($urandom);
      serial_in = 1'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      tick();
    end
    load = 1'b0; start = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
